// File: rtl/sumsq_det_pkg.sv
// Shared widths and FSM encoding for the sum-of-squares threshold detector.
package sumsq_det_pkg;
   localparam int SAMPLE_W = 12;
   localparam int CORR_W   = 16;
   localparam int SUMHSQ_W = 24;
   localparam int PROD_W   = 48;
   localparam int IDX_W    = 16;
   localparam int SQ_W     = 23;
   localparam int CSQ_W    = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      ARMED   = 2'd2,
      HOLDOFF = 2'd3
   } det_state_t;
endpackage

// File: rtl/sumsq_threshold_detector_if.sv
// Sample/correlation stream in, detection status out; no backpressure on the stream.
interface sumsq_threshold_detector_if;
   import sumsq_det_pkg::*;

   logic                       arm;
   logic                       in_valid;
   logic signed [SAMPLE_W-1:0] in_sample;
   logic signed [CORR_W-1:0]   in_corr;
   logic [SUMHSQ_W-1:0]        sumhsq;
   logic                       hit;
   logic [IDX_W-1:0]           hit_index;
   logic                       primed;
   logic                       busy;

   modport master (output arm, in_valid, in_sample, in_corr, sumhsq,
                   input  hit, hit_index, primed, busy);
   modport slave  (input  arm, in_valid, in_sample, in_corr, sumhsq,
                   output hit, hit_index, primed, busy);
endinterface

// File: rtl/sumsq_delay_line.sv
// DEPTH-deep shift register of squares; sq_old is the value pushed DEPTH advances ago.
module sumsq_delay_line #(
   parameter int DEPTH = 16,
   parameter int W     = 23
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         advance,
   input  logic [W-1:0] sq_new,
   output logic [W-1:0] sq_old
);
   logic [W-1:0] taps [DEPTH];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else if (advance) begin
         taps[0] <= sq_new;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign sq_old = taps[DEPTH-1];
endmodule

// File: rtl/sumsq_threshold_detector.sv
// Flags corr^2 << THR_SHIFT >= sumhsq * mean(x^2) over a 2^LOG2_WIN window; hit 4 cycles after the sample.
// No backpressure, one sample per cycle. SUMSQ_DET_HOLDOFF_EN selects repeat-with-holdoff over one-shot.
module sumsq_threshold_detector
   import sumsq_det_pkg::*;
#(
   parameter int LOG2_WIN    = 4,
   parameter int THR_SHIFT   = 0,
   parameter int HOLDOFF_LEN = 8
) (
   input logic                       clk,
   input logic                       reset,
   sumsq_threshold_detector_if.slave bus
);
   localparam int N       = 1 << LOG2_WIN;
   localparam int SUM_W   = SQ_W + LOG2_WIN;
   localparam int CNT_MAX = (HOLDOFF_LEN > N) ? HOLDOFF_LEN : N;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef SUMSQ_DET_HOLDOFF_EN
   localparam det_state_t AFTER_HIT = HOLDOFF;
`else
   localparam det_state_t AFTER_HIT = IDLE;
`endif

   logic flush, accept;
   logic [SAMPLE_W-1:0] smag;
   logic [CORR_W-1:0]   cmag;
   logic [SQ_W-1:0]     sq_now, sq1, sq_old;
   logic [CSQ_W-1:0]    csq_now, csq1, csq2;
   logic [IDX_W-1:0]    sample_cnt, idx1, idx2, idx3, idx_held;
   logic [SUM_W-1:0]    sumxsq;
   logic [SUMHSQ_W-1:0] avg;
   logic [PROD_W-1:0]   rhs3, lhs3;
   logic                v1, v2, v3, nz3, hit_pulse, det, eligible;
   det_state_t          state, next_state;
   logic [CNT_W-1:0]    cnt, next_cnt;

   assign flush   = reset | bus.arm;
   assign accept  = bus.in_valid & ~bus.arm;
   assign smag    = bus.in_sample[SAMPLE_W-1] ? -bus.in_sample : bus.in_sample;
   assign cmag    = bus.in_corr[CORR_W-1] ? -bus.in_corr : bus.in_corr;
   assign sq_now  = SQ_W'(smag) * SQ_W'(smag);
   assign csq_now = CSQ_W'(cmag) * CSQ_W'(cmag);
   assign avg     = SUMHSQ_W'(sumxsq >> LOG2_WIN);

   always_ff @(posedge clk) begin
      if (flush) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         sample_cnt <= '0;
         sumxsq <= '0;
      end else begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
         if (accept && sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
         if (v1) sumxsq <= sumxsq + SUM_W'(sq1) - SUM_W'(sq_old);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sq1  <= sq_now;
         csq1 <= csq_now;
         idx1 <= sample_cnt;
      end
      if (v1) begin
         csq2 <= csq1;
         idx2 <= idx1;
      end
      // sumhsq is taken here so PIO updates apply to the next sample reaching compare
      if (v2) begin
         rhs3 <= PROD_W'(bus.sumhsq) * PROD_W'(avg);
         lhs3 <= PROD_W'(csq2) << THR_SHIFT;
         nz3  <= |bus.sumhsq;
         idx3 <= idx2;
      end
   end

   sumsq_delay_line #(.DEPTH(N), .W(SQ_W)) u_delay (
      .clk     (clk),
      .clear   (flush),
      .advance (v1),
      .sq_new  (sq1),
      .sq_old  (sq_old)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         hit_pulse <= 1'b0;
         idx_held  <= '0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         hit_pulse <= det;
         if (bus.arm) idx_held <= '0;
         else if (det) idx_held <= idx3;
      end
   end

   // The sample completing FILL is itself eligible, so FILL may jump straight past ARMED.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      det        = 1'b0;
      eligible   = (state == ARMED) || (state == FILL && cnt == CNT_W'(N - 1));
      if (v3) begin
         det = eligible && nz3 && (lhs3 >= rhs3);
         case (state)
            FILL: begin
               if (cnt == CNT_W'(N - 1)) begin
                  next_cnt   = '0;
                  next_state = det ? AFTER_HIT : ARMED;
               end else begin
                  next_cnt = cnt + 1'b1;
               end
            end
            ARMED: begin
               if (det) begin
                  next_cnt   = '0;
                  next_state = AFTER_HIT;
               end
            end
`ifdef SUMSQ_DET_HOLDOFF_EN
            HOLDOFF: begin
               if (cnt == CNT_W'(HOLDOFF_LEN - 1)) begin
                  next_cnt   = '0;
                  next_state = ARMED;
               end else begin
                  next_cnt = cnt + 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
      if (bus.arm) begin
         next_state = FILL;
         next_cnt   = '0;
         det        = 1'b0;
      end
   end

   assign bus.hit       = hit_pulse;
   assign bus.hit_index = idx_held;
   assign bus.primed    = (state == ARMED);
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_sumsq_threshold_detector.sv
// Bench: two detectors (THR_SHIFT 0 and 1) on a shared stream, checked every cycle against a window model.
module tb_sumsq_threshold_detector;
   import sumsq_det_pkg::*;

   localparam int LOG2_WIN    = 4;
   localparam int N           = 16;
   localparam int HOLDOFF_LEN = 8;

   typedef struct { int cyc; int idx; } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sumsq_threshold_detector_if bus0 ();
   sumsq_threshold_detector_if bus1 ();

   sumsq_threshold_detector #(.LOG2_WIN(LOG2_WIN), .THR_SHIFT(0), .HOLDOFF_LEN(HOLDOFF_LEN)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   sumsq_threshold_detector #(.LOG2_WIN(LOG2_WIN), .THR_SHIFT(1), .HOLDOFF_LEN(HOLDOFF_LEN)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // behavioural model: window of squares, eligibility by sample index, expected hit times
   longint unsigned win[$];
   exp_t            exq [2][$];
   int              m_idx = 0;
   bit              m_run [2];
   int              m_next [2];
   longint unsigned m_h = 0;
   int              clear_at = -1;
   logic [15:0]     m_hidx [2];
   int              hits_seen [2];
   int              last_hit_idx [2];
   int              last_hit_cyc [2];

   task automatic model_flush(input int t);
      win.delete();
      m_idx = 0;
      for (int k = 0; k < 2; k++)
         while (exq[k].size() > 0 && exq[k][exq[k].size()-1].cyc >= t + 1) void'(exq[k].pop_back());
      clear_at = t + 1;
   endtask

   task automatic model_arm(input int t);
      model_flush(t);
      for (int k = 0; k < 2; k++) begin m_run[k] = 1'b1; m_next[k] = N - 1; end
   endtask

   task automatic model_sample(input int t, input int s, input int c);
      longint unsigned sum, avg, rhs, lhs, csq;
      exp_t e;
      win.push_back(longint'(s) * longint'(s));
      if (win.size() > N) void'(win.pop_front());
      sum = 0;
      foreach (win[j]) sum += win[j];
      avg = sum >> LOG2_WIN;
      rhs = m_h * avg;
      csq = longint'(c) * longint'(c);
      for (int k = 0; k < 2; k++) begin
         lhs = csq << k;
         if (m_run[k] && m_idx >= m_next[k] && m_h != 0 && lhs >= rhs) begin
            e.cyc = t + 4;
            e.idx = m_idx;
            exq[k].push_back(e);
`ifdef SUMSQ_DET_HOLDOFF_EN
            m_next[k] = m_idx + HOLDOFF_LEN + 1;
`else
            m_run[k] = 1'b0;
`endif
         end
      end
      if (m_idx < 65535) m_idx++;
   endtask

   always @(negedge clk) begin
      logic exp_hit, got_hit;
      logic [15:0] got_idx;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            if (cyc == clear_at) m_hidx[k] = 16'd0;
            exp_hit = 1'b0;
            if (exq[k].size() > 0 && exq[k][0].cyc == cyc) begin
               exp_hit = 1'b1;
               m_hidx[k] = 16'(exq[k][0].idx);
               void'(exq[k].pop_front());
            end
            got_hit = (k == 0) ? bus0.hit : bus1.hit;
            got_idx = (k == 0) ? bus0.hit_index : bus1.hit_index;
            checks++;
            if (got_hit !== exp_hit || got_idx !== m_hidx[k]) begin
               errors++;
               $display("FAIL hit_stream dut%0d cycle %0d: hit=%0b hit_index=%0d, required hit=%0b hit_index=%0d",
                        k, cyc, got_hit, got_idx, exp_hit, m_hidx[k]);
            end
            if (got_hit === 1'b1) begin
               hits_seen[k]++;
               last_hit_idx[k] = int'(got_idx);
               last_hit_cyc[k] = cyc;
            end
         end
      end
   end

   task automatic check(input string name, input longint got, input longint req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic drive(input bit a, input bit v, input int s, input int c);
      bus0.arm = a; bus0.in_valid = v; bus0.in_sample = s[11:0]; bus0.in_corr = c[15:0];
      bus1.arm = a; bus1.in_valid = v; bus1.in_sample = s[11:0]; bus1.in_corr = c[15:0];
   endtask

   task automatic step(input bit a, input bit v, input int s, input int c);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(a, v, s, c);
      if (a) model_arm(cyc);
      else if (v) model_sample(cyc, s, c);
   endtask

   task automatic step_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 0, 0);
      model_flush(cyc);
      m_run[0] = 1'b0; m_run[1] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic set_h(input int h);
      bus0.sumhsq = 24'(h); bus1.sumhsq = 24'(h);
      m_h = longint'(h);
      for (int k = 0; k < 2; k++) hits_seen[k] = 0;
   endtask

   task automatic const_run(input int n, input int s, input int c, output int t15);
      t15 = -1;
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, s, c);
         if (i == 15) t15 = cyc;
      end
   endtask

   initial begin
      int t15;
      drive(1'b0, 1'b0, 0, 0);
      set_h(0);
      m_run[0] = 1'b0; m_run[1] = 1'b0;
      m_hidx[0] = 16'd0; m_hidx[1] = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      check("reset_hit", bus0.hit, 0);
      check("reset_hit_index", bus0.hit_index, 0);
      check("reset_primed", bus0.primed, 0);
      check("reset_busy", bus0.busy, 0);

      // sumhsq = 0: no hits, primed rises 4 cycles after index 15
      set_h(0);
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 100, 100);
         if (i == 0) check("busy_in_fill", bus0.busy, 1);
         if (i == 18) check("primed_before_fill_done", bus0.primed, 0);
         if (i == 19) check("primed_after_fill_done", bus0.primed, 1);
      end
      idle(8);
      check("h0_no_hits", hits_seen[0] + hits_seen[1], 0);

      // exact equality 10000 >= 10000 at index 15
      set_h(1);
      const_run(24, 100, 100, t15);
      idle(8);
      check("eq_hit_count", hits_seen[0], 1);
      check("eq_hit_index", last_hit_idx[0], 15);
      check("eq_hit_latency", last_hit_cyc[0] - t15, 4);
      check("eq_index_held", bus0.hit_index, 15);
      check("eq_thr1_count", hits_seen[1], 1);

      // 9801 < 10000, but 19602 >= 10000 with one extra shift
      set_h(1);
      const_run(24, 100, 99, t15);
      idle(8);
      check("c99_thr0_no_hit", hits_seen[0], 0);
      check("c99_thr0_index_cleared_by_arm", bus0.hit_index, 0);
      check("c99_thr1_count", hits_seen[1], 1);
      check("c99_thr1_index", last_hit_idx[1], 15);

      // continuous matching input
      set_h(1);
      const_run(40, 100, 100, t15);
      idle(8);
`ifdef SUMSQ_DET_HOLDOFF_EN
      check("cont_hit_count", hits_seen[0], 3);
      check("cont_last_index", last_hit_idx[0], 33);
      check("cont_busy", bus0.busy, 1);
`else
      check("cont_hit_count", hits_seen[0], 1);
      check("cont_last_index", last_hit_idx[0], 15);
      check("cont_busy", bus0.busy, 0);
`endif

      // re-arm at index 10 (arm together with in_valid drops that sample)
      set_h(1);
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i <= 10; i++) step(1'b0, 1'b1, 2000, 100);
      step(1'b1, 1'b1, 2000, 2000);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 100, 100);
         if (i == 15) t15 = cyc;
      end
      idle(8);
      check("rearm_hit_count", hits_seen[0], 1);
      check("rearm_hit_index", last_hit_idx[0], 15);
      check("rearm_hit_latency", last_hit_cyc[0] - t15, 4);

      // reset 2 cycles after the detecting sample
      set_h(1);
      const_run(16, 100, 100, t15);
      step(1'b0, 1'b0, 0, 0);
      step_reset();
      step(1'b0, 1'b0, 0, 0);
      check("mid_reset_hit", bus0.hit, 0);
      check("mid_reset_hit_index", bus0.hit_index, 0);
      check("mid_reset_primed", bus0.primed, 0);
      check("mid_reset_busy", bus0.busy, 0);
      idle(8);
      check("mid_reset_no_hits", hits_seen[0] + hits_seen[1], 0);

      // randomized runs
      for (int r = 0; r < 5; r++) begin
         set_h((r == 0) ? 0 : int'($urandom_range(1, 64)));
         step(1'b1, 1'b0, 0, 0);
         for (int i = 0; i < 300; i++) begin
            bit a, v;
            int s, c;
            a = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = int'($urandom_range(0, 100)) - 50;
            c = int'($urandom_range(0, 800)) - 400;
            if ($urandom_range(0, 49) == 0) begin s = -2048; c = -32768; end
            step(a, v, s, c);
         end
         idle(8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sumsq_threshold_detector.md
# sumsq_threshold_detector

Normalised matched-filter echo detector for one ultrasonic receive channel, sitting directly downstream of the per-channel SUMHSQ PIO register. It consumes the 24-bit filter-energy constant (sum of h²) written by the NIOS, a stream of ADC samples and the aligned matched-filter output. It keeps a sliding-window sum of sample squares and flags the first sample where corr² scaled by 2^THR_SHIFT reaches sumhsq × mean(x²). It reports the sample index of that hit.

## Interface
- LOG2_WIN, 4: window length N = 2^LOG2_WIN samples, legal range 2..10
- THR_SHIFT, 0: left shift applied to corr², legal range 0..16
- HOLDOFF_LEN, 8: valid samples spent in HOLDOFF after a hit, legal range 1..65535
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- arm  in  1  single-cycle pulse; starts or restarts a detection run
- in_valid  in  1  qualifies in_sample and in_corr; there is no backpressure
- in_sample  in  12  signed ADC sample
- in_corr  in  16  signed matched-filter output, aligned with in_sample
- sumhsq  in  24  unsigned filter energy, driven from the PIO out_port
- hit  out  1  one-cycle pulse on detection
- hit_index  out  16  sample index of the latest hit; held until the next hit or arm
- primed  out  1  window is full and detection is enabled
- busy  out  1  FSM is not in IDLE

## Operation
- FSM states: IDLE, FILL, ARMED, HOLDOFF.
  - IDLE -> FILL on arm.
  - FILL -> ARMED once N valid samples have been accepted.
  - ARMED -> HOLDOFF on a detection.
  - HOLDOFF -> ARMED after HOLDOFF_LEN valid samples.
- arm in any state clears the window sum, the delay line, the sample counter and the pipeline valids, then enters FILL. An arm arriving together with in_valid drops that sample.
- Sample counter: 16-bit. Reset to 0 on arm, increments per accepted sample and saturates at 0xFFFF. The first sample after arm has index 0.
- Squares:
  - sq = in_sample², 23-bit unsigned, maximum 2^22.
  - csq = in_corr², 32-bit unsigned.
- Window sum: sumxsq is 23+LOG2_WIN bits. Each accepted sample adds sq and subtracts the sq leaving the N-deep delay line; the delay line reads as 0 during FILL. The sum never wraps.
- avg = sumxsq >> LOG2_WIN, truncated to 24 bits.
- Compare:
  - rhs = sumhsq × avg, 48-bit unsigned.
  - lhs = csq << THR_SHIFT, 48-bit unsigned.
  - A detection occurs when lhs >= rhs, the state is ARMED and sumhsq != 0.
- sumhsq == 0 disables detection. A PIO left at its reset value therefore produces no false hits.
- sumhsq is sampled at pipeline stage 3 and changes take effect immediately.
- In FILL and HOLDOFF the window keeps updating, but comparisons are discarded.

## Timing
- Pipeline stages:
  - S1 registers sq and csq.
  - S2 updates sumxsq.
  - S3 registers rhs and lhs.
  - S4 registers the compare result.
- hit asserts exactly 4 cycles after the in_valid cycle of the detecting sample. hit_index updates in that same cycle.
- The detecting sample's own square is included in the window it is compared against.
- ARMED is entered on the 4th cycle after the Nth sample's in_valid. Sample index N-1 is therefore the first sample eligible to detect.
- Back-to-back in_valid is sustained at one sample per cycle.
- Reset values: hit=0, hit_index=0, primed=0, busy=0, FSM=IDLE, sumxsq=0, counter=0, all pipeline valids=0.
- Reset mid-run kills all in-flight samples; no hit is emitted afterwards.

## Configuration
- SUMSQ_DET_HOLDOFF_EN defined: the HOLDOFF state and the HOLDOFF_LEN counter are present; detection is repeated with dead time, as described above.
- SUMSQ_DET_HOLDOFF_EN undefined: one-shot mode. ARMED -> IDLE on a detection, and a new arm is required for the next hit. HOLDOFF_LEN is ignored.

## Structure
- Package sumsq_det_pkg holds:
  - the FSM state enum;
  - the constants SAMPLE_W=12, CORR_W=16, SUMHSQ_W=24, PROD_W=48, IDX_W=16.
- Sub-module sumsq_delay_line holds the N-deep, 23-bit-wide delay line of squares. It has a synchronous clear driven by arm/reset and advances on in_valid.
- The top level holds the FSM, the counters, the accumulator, the multiply and the compare.

## Test plan
- Defaults (LOG2_WIN=4, N=16, THR_SHIFT=0), sumhsq=0, constant sample=100, corr=100 -> hit never asserts; primed rises after sample 15.
- sumhsq=1, constant sample=100, corr=100: avg=10000 and lhs=rhs=10000 -> exactly one hit, 4 cycles after index 15's in_valid, with hit_index=15.
- Same stimulus but corr=99 (9801 < 10000) -> no hit. Then THR_SHIFT=1 (19602 >= 10000) -> hit at index 15.
- With SUMSQ_DET_HOLDOFF_EN, HOLDOFF_LEN=8, continuous matching input -> hits at indices 15, 24, 33. Without the macro -> a single hit at 15, after which busy=0.
- Assert arm at index 10 of a run -> window cleared; next hit at new index 15, i.e. 16 samples after the re-arm.
- Assert reset 2 cycles after the detecting sample's in_valid -> no hit pulse, and all outputs are at their reset values the next cycle.
